// File: rtl/pacman_soc_dbg_sysclk_bridge.sv
// ---------------------------------------------------------------------------
// pacman_soc_dbg_sysclk_bridge
//
// System-clock side of the Nios II debug slave. Update-DR and update-IR
// levels arrive asynchronously from the JTAG (tck) domain and are
// synchronised here. Each update-DR rising edge captures {ir_in, sr} into a
// command buffer. The OCI core drains the buffer through a valid/ready
// handshake. Every accepted command becomes a single one-hot
// take_action / take_no_action strobe.
//
// Build option:
//   PACMAN_SOC_DBG_BRIDGE_FIFO_EN
//      When defined, the buffer is a FIFO of FIFO_DEPTH entries.
//      When undefined, a single holding register is used instead and
//      FIFO_DEPTH only sets the width of fifo_level.
//
// Parameters:
//   DR_WIDTH     scan data width; bit DR_WIDTH-1 is the action flag
//   IR_WIDTH     instruction width; NCMD = 2**IR_WIDTH strobe lanes
//   SYNC_STAGES  synchroniser flops per async input (2..4)
//   FIFO_DEPTH   command entries (power of two, >= 2)
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   vs_udr, vs_uir    update-DR / update-IR levels from tck domain (async)
//   ir_in, sr         instruction and scan register (quasi-static)
//   cmd_ready         consumer accepts the head command
//   clr_overflow      clears the overflow sticky bit
//   cmd_valid         buffer non-empty
//   cmd_ir, cmd_dr    head command (first-word fall-through)
//   jdo               DR of the last accepted command, held
//   take_action       one-hot pulse per pop when the action flag is 1
//   take_no_action    one-hot pulse per pop when the action flag is 0
//   ir_update         one-cycle pulse per vs_uir rising edge
//   overflow          sticky; a command was dropped
//   fifo_level        number of occupied entries
// ---------------------------------------------------------------------------
module pacman_soc_dbg_sysclk_bridge #(
   parameter int DR_WIDTH    = 38,
   parameter int IR_WIDTH    = 2,
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4,
   localparam int NCMD       = 2**IR_WIDTH,
   localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                vs_udr,
   input  logic                vs_uir,
   input  logic [IR_WIDTH-1:0] ir_in,
   input  logic [DR_WIDTH-1:0] sr,
   input  logic                cmd_ready,
   input  logic                clr_overflow,
   output logic                cmd_valid,
   output logic [IR_WIDTH-1:0] cmd_ir,
   output logic [DR_WIDTH-1:0] cmd_dr,
   output logic [DR_WIDTH-1:0] jdo,
   output logic [NCMD-1:0]     take_action,
   output logic [NCMD-1:0]     take_no_action,
   output logic                ir_update,
   output logic                overflow,
   output logic [LW-1:0]       fifo_level
);

   localparam int EW = IR_WIDTH + DR_WIDTH;

`ifdef PACMAN_SOC_DBG_BRIDGE_FIFO_EN
   localparam int CAP = FIFO_DEPTH;
`else
   localparam int CAP = 1;
`endif

   logic [SYNC_STAGES-1:0] udr_sync_q;
   logic [SYNC_STAGES-1:0] uir_sync_q;
   logic                   udr_dly_q;
   logic                   uir_dly_q;
   logic                   udr_edge;
   logic                   uir_edge;

   logic [LW-1:0]          level_q, level_d;
   logic [DR_WIDTH-1:0]    jdo_q, jdo_d;
   logic [NCMD-1:0]        take_action_q, take_action_d;
   logic [NCMD-1:0]        take_no_action_q, take_no_action_d;
   logic                   ir_update_q;
   logic                   overflow_q, overflow_d;

   logic [EW-1:0]          head;
   logic [IR_WIDTH-1:0]    head_ir;
   logic [DR_WIDTH-1:0]    head_dr;
   logic                   full;
   logic                   pop;
   logic                   accept;
   logic                   drop;

   // Synchroniser chains plus one delay flop each. Everything resets to 1 so
   // a level that is already high when reset releases never looks like a
   // fresh rising edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         udr_sync_q <= '1;
         uir_sync_q <= '1;
         udr_dly_q  <= 1'b1;
         uir_dly_q  <= 1'b1;
      end else begin
         udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
         uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
         udr_dly_q  <= udr_sync_q[SYNC_STAGES-1];
         uir_dly_q  <= uir_sync_q[SYNC_STAGES-1];
      end
   end

   assign udr_edge = udr_sync_q[SYNC_STAGES-1] & ~udr_dly_q;
   assign uir_edge = uir_sync_q[SYNC_STAGES-1] & ~uir_dly_q;

   // A push into a full buffer still succeeds when the head leaves in the
   // same cycle, so only an un-popped full buffer drops the command.
   assign full   = (level_q == LW'(CAP));
   assign pop    = cmd_valid & cmd_ready;
   assign accept = udr_edge & (~full | pop);
   assign drop   = udr_edge & full & ~pop;

`ifdef PACMAN_SOC_DBG_BRIDGE_FIFO_EN
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;

   // Circular command store; pointers wrap naturally because the depth is a
   // power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (accept) begin
            mem_q[wr_ptr_q] <= {ir_in, sr};
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
      end
   end

   assign head = mem_q[rd_ptr_q];
`else
   logic [EW-1:0] hold_q;

   // Single holding register; occupancy is tracked by level_q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q <= '0;
      end else if (accept) begin
         hold_q <= {ir_in, sr};
      end
   end

   assign head = hold_q;
`endif

   assign head_ir = head[EW-1 -: IR_WIDTH];
   assign head_dr = head[DR_WIDTH-1:0];

   // Next-state for occupancy, the held DR, the decoded strobes and the
   // sticky overflow. A drop wins over a simultaneous clear.
   always_comb begin
      level_d          = level_q + LW'(accept) - LW'(pop);
      jdo_d            = jdo_q;
      take_action_d    = '0;
      take_no_action_d = '0;
      overflow_d       = overflow_q;
      if (pop) begin
         jdo_d = head_dr;
         if (head_dr[DR_WIDTH-1]) begin
            take_action_d[head_ir] = 1'b1;
         end else begin
            take_no_action_d[head_ir] = 1'b1;
         end
      end
      if (clr_overflow) begin
         overflow_d = 1'b0;
      end
      if (drop) begin
         overflow_d = 1'b1;
      end
   end

   // Registered state and output strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_q          <= '0;
         jdo_q            <= '0;
         take_action_q    <= '0;
         take_no_action_q <= '0;
         ir_update_q      <= 1'b0;
         overflow_q       <= 1'b0;
      end else begin
         level_q          <= level_d;
         jdo_q            <= jdo_d;
         take_action_q    <= take_action_d;
         take_no_action_q <= take_no_action_d;
         ir_update_q      <= uir_edge;
         overflow_q       <= overflow_d;
      end
   end

   assign cmd_valid      = (level_q != '0);
   assign cmd_ir         = head_ir;
   assign cmd_dr         = head_dr;
   assign jdo            = jdo_q;
   assign take_action    = take_action_q;
   assign take_no_action = take_no_action_q;
   assign ir_update      = ir_update_q;
   assign overflow       = overflow_q;
   assign fifo_level     = level_q;

endmodule

// File: tb/tb_pacman_soc_dbg_sysclk_bridge.sv
// ---------------------------------------------------------------------------
// tb_pacman_soc_dbg_sysclk_bridge
//
// Directed bench for the debug sysclk bridge at default parameters. Each
// command the bridge should accept is pushed into an expected-command queue
// when the stimulus is issued; a monitor pops that queue whenever a
// take_action / take_no_action strobe appears and checks the strobe lanes
// and jdo. Buffer capacity follows PACMAN_SOC_DBG_BRIDGE_FIFO_EN.
// ---------------------------------------------------------------------------
module tb_pacman_soc_dbg_sysclk_bridge;

   localparam int DRW  = 38;
   localparam int IRW  = 2;
   localparam int NC   = 4;
   localparam int LVW  = 3;

`ifdef PACMAN_SOC_DBG_BRIDGE_FIFO_EN
   localparam int CAP = 4;
`else
   localparam int CAP = 1;
`endif

   logic            clk;
   logic            reset;
   logic            vs_udr;
   logic            vs_uir;
   logic [IRW-1:0]  ir_in;
   logic [DRW-1:0]  sr;
   logic            cmd_ready;
   logic            clr_overflow;
   logic            cmd_valid;
   logic [IRW-1:0]  cmd_ir;
   logic [DRW-1:0]  cmd_dr;
   logic [DRW-1:0]  jdo;
   logic [NC-1:0]   take_action;
   logic [NC-1:0]   take_no_action;
   logic            ir_update;
   logic            overflow;
   logic [LVW-1:0]  fifo_level;

   logic [IRW+DRW-1:0] sbQ[$];
   int errors = 0;
   int checks = 0;

   pacman_soc_dbg_sysclk_bridge dut (
      .clk            (clk),
      .reset          (reset),
      .vs_udr         (vs_udr),
      .vs_uir         (vs_uir),
      .ir_in          (ir_in),
      .sr             (sr),
      .cmd_ready      (cmd_ready),
      .clr_overflow   (clr_overflow),
      .cmd_valid      (cmd_valid),
      .cmd_ir         (cmd_ir),
      .cmd_dr         (cmd_dr),
      .jdo            (jdo),
      .take_action    (take_action),
      .take_no_action (take_no_action),
      .ir_update      (ir_update),
      .overflow       (overflow),
      .fifo_level     (fifo_level)
   );

   // Free-running system clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // One vs_udr pulse: high for 4 cycles, low for 4 cycles. When the bridge
   // is expected to keep the command, its {ir, dr} goes into the queue.
   task automatic applyStimulus(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                                input bit expectAccept);
      ir_in  = ir;
      sr     = dr;
      vs_udr = 1'b1;
      if (expectAccept) sbQ.push_back({ir, dr});
      repeat (4) @(negedge clk);
      vs_udr = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // Monitor: every strobe must match the oldest outstanding command.
   always @(negedge clk) begin
      logic [IRW+DRW-1:0] exp;
      logic [NC-1:0]      expA;
      logic [NC-1:0]      expN;
      if (!reset && (take_action != '0 || take_no_action != '0)) begin
         checks++;
         if (sbQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_strobe: got act=%0h noact=%0h expected none",
                     take_action, take_no_action);
         end else begin
            exp  = sbQ.pop_front();
            expA = '0;
            expN = '0;
            if (exp[DRW-1]) expA[exp[IRW+DRW-1:DRW]] = 1'b1;
            else            expN[exp[IRW+DRW-1:DRW]] = 1'b1;
            if (take_action !== expA || take_no_action !== expN || jdo !== exp[DRW-1:0]) begin
               errors++;
               $display("[TB] FAIL strobe: got act=%0h noact=%0h jdo=%0h expected act=%0h noact=%0h jdo=%0h",
                        take_action, take_no_action, jdo, expA, expN, exp[DRW-1:0]);
            end
         end
      end
   end

   initial begin
      reset        = 1'b1;
      vs_udr       = 1'b0;
      vs_uir       = 1'b0;
      ir_in        = '0;
      sr           = '0;
      cmd_ready    = 1'b0;
      clr_overflow = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] reset values");
      checkOutput("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      checkOutput("rst_level", 64'(fifo_level), 64'd0);
      checkOutput("rst_jdo", 64'(jdo), 64'd0);
      checkOutput("rst_overflow", 64'(overflow), 64'd0);
      checkOutput("rst_ir_update", 64'(ir_update), 64'd0);
      checkOutput("rst_take_action", 64'(take_action), 64'd0);
      repeat (4) @(negedge clk);

      $display("[TB] action command latency");
      cmd_ready = 1'b1;
      ir_in     = 2'd2;
      sr        = 38'h20_0000_1234;
      vs_udr    = 1'b1;
      sbQ.push_back({2'd2, 38'h20_0000_1234});
      @(negedge clk);
      checkOutput("lat_valid_e1", 64'(cmd_valid), 64'd0);
      @(negedge clk);
      checkOutput("lat_valid_e2", 64'(cmd_valid), 64'd0);
      @(negedge clk);
      checkOutput("lat_valid_e3", 64'(cmd_valid), 64'd1);
      checkOutput("lat_head_dr", 64'(cmd_dr), 64'h20_0000_1234);
      checkOutput("lat_act_e3", 64'(take_action), 64'd0);
      @(negedge clk);
      checkOutput("lat_valid_e4", 64'(cmd_valid), 64'd0);
      checkOutput("lat_jdo", 64'(jdo), 64'h20_0000_1234);
      checkOutput("lat_act_e4", 64'(take_action), 64'b0100);
      @(negedge clk);
      checkOutput("lat_act_e5", 64'(take_action), 64'd0);
      vs_udr = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] no-action command");
      applyStimulus(2'd1, 38'h00_0000_00AB, 1'b1);
      checkOutput("noact_jdo", 64'(jdo), 64'h00_0000_00AB);
      checkOutput("noact_drain", 64'(sbQ.size()), 64'd0);

      $display("[TB] overflow and ordering");
      cmd_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         logic [DRW-1:0] d;
         d = DRW'(i);
         if (i % 2 == 1) d[DRW-1] = 1'b1;
         applyStimulus(2'd3, d, (i <= CAP));
      end
      checkOutput("ovf_level", 64'(fifo_level), 64'(CAP));
      checkOutput("ovf_flag", 64'(overflow), 64'd1);
      checkOutput("ovf_head_dr", 64'(cmd_dr), 64'h20_0000_0001);
      checkOutput("ovf_head_ir", 64'(cmd_ir), 64'd3);
      cmd_ready = 1'b1;
      repeat (CAP + 3) @(negedge clk);
      checkOutput("ovf_level_drained", 64'(fifo_level), 64'd0);
      checkOutput("ovf_queue_drained", 64'(sbQ.size()), 64'd0);
      checkOutput("ovf_sticky", 64'(overflow), 64'd1);
      cmd_ready    = 1'b0;
      clr_overflow = 1'b1;
      @(negedge clk);
      clr_overflow = 1'b0;
      checkOutput("ovf_cleared", 64'(overflow), 64'd0);

      $display("[TB] push coinciding with pop while full");
      for (int i = 0; i < CAP; i++) begin
         applyStimulus(2'd0, DRW'(38'h20_0000_0010 + i), 1'b1);
      end
      checkOutput("coin_full", 64'(fifo_level), 64'(CAP));
      ir_in  = 2'd2;
      sr     = 38'h00_0000_0077;
      vs_udr = 1'b1;
      sbQ.push_back({2'd2, 38'h00_0000_0077});
      @(negedge clk);
      @(negedge clk);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      checkOutput("coin_level", 64'(fifo_level), 64'(CAP));
      checkOutput("coin_overflow", 64'(overflow), 64'd0);
      @(negedge clk);
      vs_udr = 1'b0;
      repeat (4) @(negedge clk);
      cmd_ready = 1'b1;
      repeat (CAP + 3) @(negedge clk);
      cmd_ready = 1'b0;
      checkOutput("coin_drained", 64'(fifo_level), 64'd0);
      checkOutput("coin_queue", 64'(sbQ.size()), 64'd0);

      $display("[TB] reset mid-operation and input high across reset");
      applyStimulus(2'd1, 38'h3F_0000_0001, 1'b1);
      checkOutput("mid_level", 64'(fifo_level), 64'd1);
      reset = 1'b1;
      #1;
      checkOutput("mid_async_valid", 64'(cmd_valid), 64'd0);
      checkOutput("mid_async_jdo", 64'(jdo), 64'd0);
      sbQ.delete();
      vs_udr = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("hi_rst_valid", 64'(cmd_valid), 64'd0);
      checkOutput("hi_rst_level", 64'(fifo_level), 64'd0);
      cmd_ready = 1'b1;
      repeat (3) @(negedge clk);
      vs_udr    = 1'b0;
      cmd_ready = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("hi_rst_jdo", 64'(jdo), 64'd0);

      $display("[TB] ir_update pulse");
      vs_uir = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         checkOutput($sformatf("ir_update_e%0d", k), 64'(ir_update), (k == 3) ? 64'd1 : 64'd0);
      end
      vs_uir = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("uir_level", 64'(fifo_level), 64'd0);
      checkOutput("uir_queue", 64'(sbQ.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
